// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM states, exception vector
// default and redirect-source encoding.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_EXC  = 2'd1,
        RD_ERET = 2'd2,
        RD_BR   = 2'd3
    } redir_src_t;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority redirect selector: exception > eret > branch/jump.
module pc_redirect_mux
    import pc_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF)
) (
    input  logic             exc_flush,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic             redirect,
    output logic [WIDTH-1:0] target
);

    redir_src_t src_s;

    // Encode the winning redirect source.
    always_comb begin
        src_s = RD_NONE;
        if (exc_flush) begin
            src_s = RD_EXC;
        end else if (eret) begin
            src_s = RD_ERET;
        end else if (br_taken) begin
            src_s = RD_BR;
        end else begin
            src_s = RD_NONE;
        end
    end

    // Select the target address for the winning source.
    always_comb begin
        redirect = 1'b1;
        target   = '0;
        case (src_s)
            RD_EXC:  target = EXC_VECTOR;
            RD_ERET: target = epc;
            RD_BR:   target = br_target;
            default: redirect = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC front-end sequencer: drives pc en/d, issues fetches, buffers the word.
// Optional misaligned-fetch trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_q,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_d,
    input  logic             exc_flush,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             stall,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst_out,
    output logic [WIDTH-1:0] inst_pc
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             inst_adel
`endif
);

    fetch_state_t     state_q;
    logic             discard_q;
    logic             adel_q;
    logic [WIDTH-1:0] inst_out_q;
    logic [WIDTH-1:0] inst_pc_q;
    logic             redirect_s;
    logic [WIDTH-1:0] target_s;
    logic             misalign_s;

    pc_redirect_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_mux (
        .exc_flush (exc_flush),
        .eret      (eret),
        .epc       (epc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .redirect  (redirect_s),
        .target    (target_s)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_s = (pc_q[1:0] != 2'b00);
    assign inst_adel  = adel_q;
`else
    assign misalign_s = 1'b0;
`endif

    // Fetch FSM; a redirect while a fetch is in flight marks its data for discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            discard_q  <= 1'b0;
            adel_q     <= 1'b0;
            inst_out_q <= '0;
            inst_pc_q  <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (misalign_s) begin
                        if (!redirect_s) begin
                            state_q    <= S_VALID;
                            adel_q     <= 1'b1;
                            inst_out_q <= '0;
                            inst_pc_q  <= pc_q;
                        end
                    end else if (inst_addr_ok) begin
                        state_q   <= S_WAIT;
                        discard_q <= redirect_s;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        discard_q <= 1'b0;
                        if (discard_q || redirect_s) begin
                            state_q <= S_REQ;
                        end else begin
                            state_q    <= S_VALID;
                            inst_out_q <= inst_rdata;
                            inst_pc_q  <= pc_q;
                        end
                    end else if (redirect_s) begin
                        discard_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (redirect_s) begin
                        state_q <= S_REQ;
                        adel_q  <= 1'b0;
                    end else if (!stall && !adel_q) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q   <= S_REQ;
                    discard_q <= 1'b0;
                    adel_q    <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle pc update, bus request and decode-valid qualification.
    always_comb begin
        pc_en      = 1'b0;
        pc_d       = pc_q + WIDTH'(4);
        inst_req   = 1'b0;
        inst_valid = 1'b0;
        if (rst) begin
            pc_en = 1'b0;
        end else begin
            if (redirect_s) begin
                pc_en = 1'b1;
                pc_d  = target_s;
            end else if (state_q == S_VALID && !stall && !adel_q) begin
                pc_en = 1'b1;
            end else begin
                pc_en = 1'b0;
            end
            inst_req   = (state_q == S_REQ) && !misalign_s;
            inst_valid = (state_q == S_VALID) && !redirect_s;
        end
    end

    assign inst_addr = pc_q;
    assign inst_out  = inst_out_q;
    assign inst_pc   = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a local pc register and scripted bus.
// Define PC_ALIGN_CHECK_EN to also exercise the misaligned-fetch trap.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_reg;
    logic        pc_en;
    logic [31:0] pc_d;
    logic        exc_flush, eret, br_taken, stall;
    logic [31:0] epc, br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic [31:0] inst_out, inst_pc;
`ifdef PC_ALIGN_CHECK_EN
    logic        inst_adel;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External pc register, reset to the boot address.
    always_ff @(posedge clk) begin
        if (rst) pc_reg <= 32'hBFC00000;
        else if (pc_en) pc_reg <= pc_d;
    end

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc_q         (pc_reg),
        .pc_en        (pc_en),
        .pc_d         (pc_d),
        .exc_flush    (exc_flush),
        .eret         (eret),
        .epc          (epc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .stall        (stall),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .inst_adel    (inst_adel)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; exc_flush = 1'b0; eret = 1'b0; br_taken = 1'b0; stall = 1'b0;
        epc = 32'h0; br_target = 32'h0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        settle();
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        cyc();
        cyc();
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_out", inst_out, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        rst = 1'b0;

        // Reset then run: addr_ok at t, data_ok at t+1
        inst_addr_ok = 1'b1; settle();
        chk("run_req", {31'd0, inst_req}, 32'd1);
        chk("run_addr", inst_addr, 32'hBFC00000);
        chk("run_pc_en_t", {31'd0, pc_en}, 32'd0);
        cyc();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h11111111; settle();
        chk("run_req_wait", {31'd0, inst_req}, 32'd0);
        chk("run_valid_t1", {31'd0, inst_valid}, 32'd0);
        cyc();
        inst_data_ok = 1'b0; settle();
        chk("run_valid_t2", {31'd0, inst_valid}, 32'd1);
        chk("run_out", inst_out, 32'h11111111);
        chk("run_inst_pc", inst_pc, 32'hBFC00000);
        chk("run_pc_en_t2", {31'd0, pc_en}, 32'd1);
        chk("run_pc_d", pc_d, 32'hBFC00004);
        cyc();
        chk("run_req_t3", {31'd0, inst_req}, 32'd1);
        chk("run_addr_t3", inst_addr, 32'hBFC00004);
        chk("run_valid_t3", {31'd0, inst_valid}, 32'd0);

        // Stall in S_VALID for 5 cycles
        inst_addr_ok = 1'b1; cyc();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h22222222; cyc();
        inst_data_ok = 1'b0; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            settle();
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_out", inst_out, 32'h22222222);
            chk("stall_inst_pc", inst_pc, 32'hBFC00004);
            chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
        end
        cyc();
        stall = 1'b0; settle();
        chk("unstall_pc_en", {31'd0, pc_en}, 32'd1);
        chk("unstall_pc_d", pc_d, 32'hBFC00008);

        // Redirect during S_WAIT drops the returned word
        cyc();
        inst_addr_ok = 1'b1; settle();
        chk("wr_addr", inst_addr, 32'hBFC00008);
        cyc();
        inst_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'hBFC00100; settle();
        chk("wr_pc_en", {31'd0, pc_en}, 32'd1);
        chk("wr_pc_d", pc_d, 32'hBFC00100);
        chk("wr_req", {31'd0, inst_req}, 32'd0);
        cyc();
        br_taken = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h33333333; settle();
        chk("wr_valid_data", {31'd0, inst_valid}, 32'd0);
        chk("wr_pc_en_data", {31'd0, pc_en}, 32'd0);
        cyc();
        inst_data_ok = 1'b0; settle();
        chk("wr_valid_after", {31'd0, inst_valid}, 32'd0);
        chk("wr_req_after", {31'd0, inst_req}, 32'd1);
        chk("wr_addr_after", inst_addr, 32'hBFC00100);

        // Simultaneous redirects, accepted in S_REQ, then eret over branch in S_WAIT
        exc_flush = 1'b1; eret = 1'b1; br_taken = 1'b1;
        epc = 32'h80001000; br_target = 32'hBFC00200; inst_addr_ok = 1'b1; settle();
        chk("sim_pc_en", {31'd0, pc_en}, 32'd1);
        chk("sim_pc_d_exc", pc_d, 32'hBFC00380);
        cyc();
        exc_flush = 1'b0; inst_addr_ok = 1'b0; settle();
        chk("sim_pc_d_eret", pc_d, 32'h80001000);
        cyc();
        eret = 1'b0; br_taken = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h44444444; settle();
        chk("sim_valid_drop", {31'd0, inst_valid}, 32'd0);
        cyc();
        inst_data_ok = 1'b0; settle();
        chk("sim_req", {31'd0, inst_req}, 32'd1);
        chk("sim_addr", inst_addr, 32'h80001000);

        // Redirect with stall in S_VALID
        inst_addr_ok = 1'b1; cyc();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55555555; cyc();
        inst_data_ok = 1'b0; stall = 1'b1; settle();
        chk("rs_valid_pre", {31'd0, inst_valid}, 32'd1);
        chk("rs_inst_pc", inst_pc, 32'h80001000);
        br_taken = 1'b1; br_target = 32'h00000040; settle();
        chk("rs_valid", {31'd0, inst_valid}, 32'd0);
        chk("rs_pc_en", {31'd0, pc_en}, 32'd1);
        chk("rs_pc_d", pc_d, 32'h00000040);
        cyc();
        br_taken = 1'b0; stall = 1'b0; settle();
        chk("rs_req", {31'd0, inst_req}, 32'd1);
        chk("rs_addr", inst_addr, 32'h00000040);
        chk("rs_valid_after", {31'd0, inst_valid}, 32'd0);

        // pc+4 wraps at the top of the address space
        br_taken = 1'b1; br_target = 32'hFFFFFFFC; settle();
        chk("wrap_redir_pc_en", {31'd0, pc_en}, 32'd1);
        cyc();
        br_taken = 1'b0; inst_addr_ok = 1'b1; settle();
        chk("wrap_addr", inst_addr, 32'hFFFFFFFC);
        cyc();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h66666666; cyc();
        inst_data_ok = 1'b0; settle();
        chk("wrap_valid", {31'd0, inst_valid}, 32'd1);
        chk("wrap_pc_d", pc_d, 32'h00000000);

        // Reset mid-fetch abandons the transaction
        cyc();
        inst_addr_ok = 1'b1; cyc();
        inst_addr_ok = 1'b0; rst = 1'b1; settle();
        chk("mrst_req", {31'd0, inst_req}, 32'd0);
        chk("mrst_pc_en", {31'd0, pc_en}, 32'd0);
        cyc();
        rst = 1'b0; settle();
        chk("mrst_req_after", {31'd0, inst_req}, 32'd1);
        chk("mrst_addr", inst_addr, 32'hBFC00000);
        chk("mrst_valid", {31'd0, inst_valid}, 32'd0);

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned pc traps in S_VALID until an exception redirect
        br_taken = 1'b1; br_target = 32'hBFC00002; cyc();
        br_taken = 1'b0; settle();
        chk("al_req", {31'd0, inst_req}, 32'd0);
        cyc();
        chk("al_valid", {31'd0, inst_valid}, 32'd1);
        chk("al_adel", {31'd0, inst_adel}, 32'd1);
        chk("al_out", inst_out, 32'h0);
        chk("al_inst_pc", inst_pc, 32'hBFC00002);
        chk("al_pc_en", {31'd0, pc_en}, 32'd0);
        stall = 1'b1; cyc();
        chk("al_valid_hold", {31'd0, inst_valid}, 32'd1);
        stall = 1'b0; exc_flush = 1'b1; settle();
        chk("al_exc_pc_d", pc_d, 32'hBFC00380);
        chk("al_exc_valid", {31'd0, inst_valid}, 32'd0);
        cyc();
        exc_flush = 1'b0; settle();
        chk("al_req_after", {31'd0, inst_req}, 32'd1);
        chk("al_adel_after", {31'd0, inst_adel}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
